// File: rtl/keypad_pkg.sv
// Key codes and entry-state encoding shared by the keypad decoder
// and the entry controller.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        OUTPUT
    } entry_state_t;

endpackage

// File: rtl/entry_timeout_timer.sv
// Inactivity timer: pulses expired when run has been held for
// TIMEOUT_CYCLES cycles without a restart. A zero parameter disables it.
module entry_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TOP  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run || restart) begin
            cnt_d = '0;
        end else if (cnt_q != TOP) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT_CYCLES > 0) && run && !restart && (cnt_q == LAST);

endmodule

// File: rtl/keypad_entry_controller.sv
// Collects keypad events into a BCD code with backspace, clear, commit
// and inactivity timeout; hands committed codes out over valid/ready.
module keypad_entry_controller
    import keypad_pkg::*;
#(
    parameter int  MAX_DIGITS     = 4,
    parameter int  MIN_DIGITS     = 1,
    parameter int  TIMEOUT_CYCLES = 50_000_000,
    localparam int CNT_W          = $clog2(MAX_DIGITS + 1),
    localparam int BUF_W          = 4 * MAX_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       tecla_value,
    input  logic             tecla_valid,
    input  logic             code_ready,
    output logic             code_valid,
    output logic [BUF_W-1:0] code_bcd,
    output logic [CNT_W-1:0] code_len,
    output logic [BUF_W-1:0] entry_bcd,
    output logic [CNT_W-1:0] entry_len,
    output logic             entry_error,
    output logic             timeout,
    output logic             key_dropped
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(MIN_DIGITS);
    localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

    entry_state_t     state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, code_q, code_d;
    logic [CNT_W-1:0] len_q, len_d, clen_q, clen_d;
    logic             tecla_q, tecla_d;
    logic             err_q, err_d, to_q, to_d, drop_q, drop_d;
    logic             key_ev, is_digit, is_enter, is_back, is_clear;
    logic             restart, expired;
    logic [BUF_W-1:0] shifted;

    assign tecla_d  = tecla_valid;
    assign key_ev   = tecla_valid & ~tecla_q;
    assign is_digit = tecla_value <= 4'd9;
    assign is_enter = tecla_value == KEY_ENTER;
    assign is_back  = tecla_value == KEY_BACK;
    assign is_clear = tecla_value == KEY_CLEAR;
    assign shifted  = (buf_q << 4) | BUF_W'(tecla_value);

    entry_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == ENTRY),
        .restart(restart),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        code_d  = code_q;
        clen_d  = clen_q;
        err_d   = 1'b0;
        to_d    = 1'b0;
        drop_d  = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_ev && is_digit) begin
                    buf_d   = shifted;
                    len_d   = LEN_ONE;
                    state_d = ENTRY;
                end else if (key_ev && is_enter) begin
                    err_d = (MIN_DIGITS >= 1);
                end
            end
            ENTRY: begin
                restart = key_ev & (is_digit | is_enter | is_back | is_clear);
                if (restart) begin
                    unique case (1'b1)
                        is_digit: begin
                            if (len_q < LEN_MAX) begin
                                buf_d = shifted;
                                len_d = len_q + 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        is_back: begin
                            buf_d = buf_q >> 4;
                            len_d = len_q - 1'b1;
                            if (len_q == LEN_ONE) state_d = IDLE;
                        end
                        is_clear: begin
                            buf_d   = '0;
                            len_d   = '0;
                            state_d = IDLE;
                        end
                        is_enter: begin
                            if (len_q >= LEN_MIN) begin
                                code_d  = buf_q;
                                clen_d  = len_q;
                                state_d = OUTPUT;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (expired) begin
                    buf_d   = '0;
                    len_d   = '0;
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            OUTPUT: begin
                // keys cannot reach the buffer until the code is taken
                drop_d = key_ev;
                if (code_ready) begin
                    buf_d   = '0;
                    len_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            len_q   <= '0;
            code_q  <= '0;
            clen_q  <= '0;
            tecla_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            code_q  <= code_d;
            clen_q  <= clen_d;
            tecla_q <= tecla_d;
            err_q   <= err_d;
            to_q    <= to_d;
            drop_q  <= drop_d;
        end
    end

    assign code_valid  = (state_q == OUTPUT);
    assign code_bcd    = code_q;
    assign code_len    = clen_q;
    assign entry_bcd   = buf_q;
    assign entry_len   = len_q;
    assign entry_error = err_q;
    assign timeout     = to_q;
    assign key_dropped = drop_q;

endmodule
